lsu_store_buffer: RTL and testbench

//  In-order FIFO of speculative stores between dcache M1 and commit.
//  - Accepts one sb_entry_t per cycle from the M1 write handshake.
//  - Presents the oldest entry to commit, which drains it when a store retires.
//  - Exposes every entry, in age order, for load store-to-load forwarding.
//  - Raises a stall to the dcache pipeline when it cannot accept a store.

---
 rtl/lsu_store_buffer_pkg.sv | 30 +++
 rtl/handshake_if.sv | 9 +
 rtl/lsu_store_buffer.sv | 131 +++++++++++++
 tb/tb_lsu_store_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_store_buffer_pkg.sv
// Shared store-buffer types: the sb_entry_t record, default depth and the byte-merge helper.
package lsu_store_buffer_pkg;

    localparam int WAY_NUM     = 2;
    localparam int SB_SIZE_DEF = 4;

    typedef struct packed {
        logic [31:0]        target_addr;
        logic [31:0]        write_data;
        logic [3:0]         wstrb;
        logic               valid;
        logic               uncached;
        logic [WAY_NUM-1:0] hit;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

    // Byte lanes of new_data replace old_data wherever strb is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_data;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Generic valid/ready/data handshake bundle with sender and receiver views.
interface handshake_if #(parameter int W = lsu_store_buffer_pkg::SB_ENTRY_W);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport sender   (output valid, output data, input ready);
    modport receiver (input valid, input data, output ready);
endinterface

// File: rtl/lsu_store_buffer.sv
// In-order store buffer between dcache M1 and commit, with age-ordered forwarding view.
// Optional store coalescing into the youngest entry is enabled by defining SB_COALESCE_EN.
module lsu_store_buffer
    import lsu_store_buffer_pkg::*;
#(
    parameter int SB_SIZE = SB_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    handshake_if.receiver           sb_entry_receiver,
    handshake_if.sender             sb_entry_sender,
    output sb_entry_t [SB_SIZE-1:0] sb_entry_o,
    output logic                    sb_stall
);

    localparam int PTR_W = $clog2(SB_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SB_SIZE);

    typedef logic [PTR_W-1:0] ptr_t;

    sb_entry_t          entry_q [SB_SIZE];
    sb_entry_t          entry_d [SB_SIZE];
    logic [SB_SIZE-1:0] valid_q, valid_d;
    ptr_t               head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    sb_entry_t in_entry, wr_entry;
    logic      full, empty, enq_fire, deq_fire, merge, alloc;

    assign in_entry = sb_entry_t'(sb_entry_receiver.data);
    assign full     = (count_q == FULL);
    assign empty    = (count_q == '0);
    assign sb_stall = full;

    assign sb_entry_sender.valid = !empty;
    assign sb_entry_sender.data  = sb_entry_o[0];
    assign deq_fire = sb_entry_sender.valid & sb_entry_sender.ready;
    assign enq_fire = sb_entry_receiver.valid & sb_entry_receiver.ready;

`ifdef SB_COALESCE_EN
    ptr_t      young_idx;
    sb_entry_t merged_entry;

    assign young_idx = tail_q - ptr_t'(1);
    // The youngest entry cannot absorb a store while it is also leaving as the head.
    assign merge = !empty && valid_q[young_idx]
                && (in_entry.target_addr[31:2] == entry_q[young_idx].target_addr[31:2])
                && !in_entry.uncached && !entry_q[young_idx].uncached
                && !(deq_fire && (count_q == CNT_W'(1)));
    assign sb_entry_receiver.ready = !full || merge;

    always_comb begin
        merged_entry            = entry_q[young_idx];
        merged_entry.wstrb      = entry_q[young_idx].wstrb | in_entry.wstrb;
        merged_entry.write_data = merge_bytes(entry_q[young_idx].write_data,
                                              in_entry.write_data, in_entry.wstrb);
        merged_entry.hit        = in_entry.hit;
    end
`else
    assign merge = 1'b0;
    assign sb_entry_receiver.ready = !full;
`endif

    assign alloc = enq_fire && !flush_i && !merge;

    always_comb begin
        wr_entry       = in_entry;
        wr_entry.valid = 1'b1;
        entry_d        = entry_q;
        valid_d        = valid_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q + CNT_W'(alloc) - CNT_W'(deq_fire);

        if (deq_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ptr_t'(1);
        end
        if (alloc) begin
            entry_d[tail_q] = wr_entry;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + ptr_t'(1);
        end
`ifdef SB_COALESCE_EN
        if (enq_fire && !flush_i && merge) entry_d[young_idx] = merged_entry;
`endif
        // A same-cycle dequeue has already been seen by commit; flush only drops what remains.
        if (flush_i) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    // Rotate storage into age order; unoccupied slots read as all-zero.
    for (genvar i = 0; i < SB_SIZE; i++) begin : g_rot
        ptr_t      idx;
        sb_entry_t slot;
        always_comb begin
            idx        = head_q + ptr_t'(i);
            slot       = entry_q[idx];
            slot.valid = entry_q[idx].valid & valid_q[idx];
        end
        assign sb_entry_o[i] = (CNT_W'(i) < count_q) ? slot : '0;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(deq_fire && empty));

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed self-checking bench for lsu_store_buffer (default build or SB_COALESCE_EN).
module tb_lsu_store_buffer;
    import lsu_store_buffer_pkg::*;

    localparam int N = SB_SIZE_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    sb_entry_t [N-1:0] sb_entry_o;
    logic sb_stall;
    sb_entry_t tx_data;
    int errors = 0;
    int checks = 0;

    handshake_if #(.W(SB_ENTRY_W)) rx_if ();
    handshake_if #(.W(SB_ENTRY_W)) tx_if ();

    assign tx_data = sb_entry_t'(tx_if.data);

    lsu_store_buffer #(.SB_SIZE(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .sb_entry_receiver (rx_if),
        .sb_entry_sender   (tx_if),
        .sb_entry_o        (sb_entry_o),
        .sb_stall          (sb_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        sb_entry_t e;
        e             = '0;
        e.target_addr = a;
        e.write_data  = d;
        e.wstrb       = s;
        e.hit         = WAY_NUM'(1);
        rx_if.valid   = v;
        rx_if.data    = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (rx_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rx_if.ready); end
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL reset_sender_valid got %b exp 0", tx_if.valid); end
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", sb_stall); end
        checks++; if (sb_entry_o !== '0) begin errors++; $display("FAIL reset_entries got %h exp 0", sb_entry_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        #1;
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL fill_stall got %b exp 1", sb_stall); end
        checks++; if (rx_if.ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", rx_if.ready); end
        checks++; if (sb_entry_o[0].target_addr !== 32'h100) begin errors++; $display("FAIL fill_slot0 got %h exp 100", sb_entry_o[0].target_addr); end
        checks++; if (sb_entry_o[3].target_addr !== 32'h10C) begin errors++; $display("FAIL fill_slot3 got %h exp 10c", sb_entry_o[3].target_addr); end
        checks++; if (sb_entry_o[3].valid !== 1'b1) begin errors++; $display("FAIL fill_slot3_valid got %b exp 1", sb_entry_o[3].valid); end
        checks++; if (sb_entry_o[2].write_data !== 32'hD000_0002) begin errors++; $display("FAIL fill_slot2_data got %h exp d0000002", sb_entry_o[2].write_data); end
    endtask

    task automatic test_drain_wrap();
        tx_if.ready = 1'b1;
        #1;
        checks++; if (tx_data.target_addr !== 32'h100) begin errors++; $display("FAIL drain_head got %h exp 100", tx_data.target_addr); end
        tick();
        tx_if.ready = 1'b0;
        #1;
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL drain_stall got %b exp 0", sb_stall); end
        checks++; if (sb_entry_o[0].target_addr !== 32'h104) begin errors++; $display("FAIL drain_slot0 got %h exp 104", sb_entry_o[0].target_addr); end
        checks++; if (sb_entry_o[3] !== '0) begin errors++; $display("FAIL drain_slot3_empty got %h exp 0", sb_entry_o[3]); end
        drive(1'b1, 32'h110, 32'hD000_0004, 4'hF);
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        checks++; if (sb_entry_o[3].target_addr !== 32'h110) begin errors++; $display("FAIL wrap_slot3 got %h exp 110", sb_entry_o[3].target_addr); end
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL wrap_stall got %b exp 1", sb_stall); end
        tx_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tx_data.target_addr !== 32'h104 + 32'(4 * i)) begin errors++; $display("FAIL wrap_drain%0d got %h exp %h", i, tx_data.target_addr, 32'h104 + 32'(4 * i)); end
            tick();
        end
        tx_if.ready = 1'b0;
        #1;
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", tx_if.valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h400, 32'h4, 4'hF);
        tick();
        drive(1'b1, 32'h404, 32'h5, 4'hF);
        tick();
        flush_i = 1'b1;
        tx_if.ready = 1'b1;
        drive(1'b1, 32'h408, 32'h6, 4'hF);
        #1;
        checks++; if (tx_if.valid !== 1'b1 || tx_data.target_addr !== 32'h400) begin errors++; $display("FAIL flush_deliver got v=%b a=%h exp v=1 a=400", tx_if.valid, tx_data.target_addr); end
        tick();
        flush_i = 1'b0;
        tx_if.ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        #1;
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL flush_sender_valid got %b exp 0", tx_if.valid); end
        checks++; if (sb_entry_o !== '0) begin errors++; $display("FAIL flush_entries got %h exp 0", sb_entry_o); end
        drive(1'b1, 32'h500, 32'h7, 4'hF);
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        checks++; if (sb_entry_o[0].target_addr !== 32'h500 || sb_entry_o[0].valid !== 1'b1) begin errors++; $display("FAIL flush_refill got a=%h v=%b exp a=500 v=1", sb_entry_o[0].target_addr, sb_entry_o[0].valid); end
        checks++; if (sb_entry_o[1] !== '0) begin errors++; $display("FAIL flush_no_ghost got %h exp 0", sb_entry_o[1]); end
        tx_if.ready = 1'b1;
        tick();
        tx_if.ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h200, 32'hAABB_CCDD, 4'hF);
        #1;
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass got %b exp 0", tx_if.valid); end
        tick();
        drive(1'b1, 32'h204, 32'h0102_0304, 4'hF);
        tx_if.ready = 1'b1;
        #1;
        checks++; if (tx_if.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", tx_if.valid); end
        checks++; if (tx_data.write_data !== 32'hAABB_CCDD || tx_data.target_addr !== 32'h200) begin errors++; $display("FAIL b2b_first got a=%h d=%h exp a=200 d=aabbccdd", tx_data.target_addr, tx_data.write_data); end
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        checks++; if (tx_data.target_addr !== 32'h204) begin errors++; $display("FAIL b2b_second got %h exp 204", tx_data.target_addr); end
        checks++; if (sb_entry_o[1].valid !== 1'b0) begin errors++; $display("FAIL b2b_count got %b exp 0", sb_entry_o[1].valid); end
        tick();
        tx_if.ready = 1'b0;
        #1;
        checks++; if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", tx_if.valid); end
    endtask

    task automatic test_coalesce();
        drive(1'b1, 32'h300, 32'h0000_0011, 4'h1);
        tick();
        drive(1'b1, 32'h300, 32'h0022_0000, 4'h4);
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
`ifdef SB_COALESCE_EN
        checks++; if (sb_entry_o[0].wstrb !== 4'h5) begin errors++; $display("FAIL merge_strb got %h exp 5", sb_entry_o[0].wstrb); end
        checks++; if (sb_entry_o[0].write_data !== 32'h0022_0011) begin errors++; $display("FAIL merge_data got %h exp 00220011", sb_entry_o[0].write_data); end
        checks++; if (sb_entry_o[1].valid !== 1'b0) begin errors++; $display("FAIL merge_single got %b exp 0", sb_entry_o[1].valid); end
`else
        checks++; if (sb_entry_o[0].wstrb !== 4'h1 || sb_entry_o[0].write_data !== 32'h11) begin errors++; $display("FAIL nomerge_first got s=%h d=%h exp s=1 d=11", sb_entry_o[0].wstrb, sb_entry_o[0].write_data); end
        checks++; if (sb_entry_o[1].wstrb !== 4'h4 || sb_entry_o[1].write_data !== 32'h0022_0000) begin errors++; $display("FAIL nomerge_second got s=%h d=%h exp s=4 d=00220000", sb_entry_o[1].wstrb, sb_entry_o[1].write_data); end
        checks++; if (sb_entry_o[1].valid !== 1'b1) begin errors++; $display("FAIL nomerge_two got %b exp 1", sb_entry_o[1].valid); end
`endif
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset_flush();
        drive(1'b1, 32'h600, 32'h8, 4'hF);
        tick();
        drive(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        flush_i = 1'b1;
        tick();
        rst_n = 1'b1;
        flush_i = 1'b0;
        #1;
        checks++; if (sb_entry_o !== '0 || tx_if.valid !== 1'b0) begin errors++; $display("FAIL rstflush_state got v=%b o=%h exp v=0 o=0", tx_if.valid, sb_entry_o); end
        checks++; if (rx_if.ready !== 1'b1 || sb_stall !== 1'b0) begin errors++; $display("FAIL rstflush_ready got r=%b s=%b exp r=1 s=0", rx_if.ready, sb_stall); end
    endtask

    initial begin
        tx_if.ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        test_reset();
        test_fill();
        test_drain_wrap();
        test_flush();
        test_back_to_back();
        test_coalesce();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
